// File: rtl/imem_loader_pkg.sv
// Shared constants and types for the UART-driven instruction memory loader.
package imem_loader_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned CNT_W   = 9;
    localparam int unsigned TIMER_W = 16;

    localparam logic [TIMER_W-1:0] TIMEOUT_DEFAULT = 16'd50000;

    typedef enum logic [1:0] {
        ST_WAIT_LEN = 2'd0,
        ST_LOAD     = 2'd1,
        ST_RUN      = 2'd2,
        ST_ERROR    = 2'd3
    } loader_state_e;

    // A length byte of zero stands for a full 256-byte image.
    function automatic logic [CNT_W-1:0] len_to_count(input logic [BYTE_W-1:0] len);
        return (len == '0) ? CNT_W'(256) : CNT_W'(len);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake between the UART receiver and the loader.
interface imem_loader_if;

    logic                                rx_valid;
    logic [imem_loader_pkg::BYTE_W-1:0]  rx_data;
    logic                                rx_ready;

    modport master (output rx_valid, output rx_data, input rx_ready);
    modport slave  (input rx_valid, input rx_data, output rx_ready);

endinterface

// File: rtl/imem_loader_timeout.sv
// Idle counter for the LOAD phase; flags when the last allowed idle cycle is reached.
module imem_loader_timeout
    import imem_loader_pkg::*;
#(
    parameter logic [TIMER_W-1:0] LIMIT = TIMEOUT_DEFAULT
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    output logic terminal_c
);

    logic [TIMER_W-1:0] count_q;

    // Saturates at the terminal value so a long stall cannot wrap back to zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (!terminal_c) begin
            count_q <= count_q + TIMER_W'(1);
        end
    end

    assign terminal_c = (count_q == (LIMIT - TIMER_W'(1)));

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte image into instruction memory, then releases the CPU.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [TIMER_W-1:0] TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic               clock,
    input  logic               reset_n,
    imem_loader_if.slave       rx,
    input  logic               load_start,
    input  logic [ADDR_W-1:0]  cpu_pc,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [BYTE_W-1:0]  imem_w_data,
    output logic               imem_w_en,
    output logic               cpu_reset,
    output logic               busy,
    output logic               err
);

    loader_state_e      state_q, state_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic               idle_clear;
    logic               idle_terminal_c;

    imem_loader_timeout #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear      (idle_clear),
        .terminal_c (idle_terminal_c)
    );

    // Status outputs are registered from the next state so they move on the transition edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_WAIT_LEN;
            ptr_q       <= '0;
            remaining_q <= '0;
            cpu_reset   <= 1'b1;
            busy        <= 1'b1;
            err         <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            remaining_q <= remaining_d;
            cpu_reset   <= (state_d != ST_RUN);
            busy        <= (state_d == ST_WAIT_LEN) || (state_d == ST_LOAD);
            err         <= (state_d == ST_ERROR);
        end
    end

    // Next-state, datapath updates and combinational memory/handshake outputs.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        remaining_d = remaining_q;
        idle_clear  = 1'b1;
        rx.rx_ready = 1'b0;
        imem_addr   = '0;
        imem_w_data = '0;
        imem_w_en   = 1'b0;

        case (state_q)
            ST_WAIT_LEN: begin
                rx.rx_ready = 1'b1;
                if (rx.rx_valid) begin
                    remaining_d = len_to_count(rx.rx_data);
                    ptr_d       = '0;
                    state_d     = ST_LOAD;
                end
            end

            ST_LOAD: begin
                rx.rx_ready = 1'b1;
                idle_clear  = 1'b0;
                imem_addr   = ptr_q;
                imem_w_data = rx.rx_data;
                imem_w_en   = rx.rx_valid && reset_n;
                // An accept on the terminal idle cycle takes priority over the abort.
                if (rx.rx_valid) begin
                    idle_clear  = 1'b1;
                    ptr_d       = ptr_q + ADDR_W'(1);
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = ST_RUN;
                    end
                end else if (idle_terminal_c) begin
                    state_d = ST_ERROR;
                end
            end

            ST_RUN: begin
                imem_addr = cpu_pc;
                if (load_start) begin
                    state_d = ST_WAIT_LEN;
                end
            end

            ST_ERROR: begin
                if (load_start) begin
                    state_d = ST_WAIT_LEN;
                end
            end

            default: begin
                state_d = ST_WAIT_LEN;
            end
        endcase
    end

endmodule
